// File: rtl/obstacle_collision.sv
// obstacle_collision: per-frame bounding-box hit test with lives, invulnerability cooldown and pass scoring
module obstacle_collision #(
  parameter int PLAYER_W      = 16,
  parameter int PLAYER_H      = 16,
  parameter int OBSTACLE_W    = 16,
  parameter int OBSTACLE_H    = 16,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 30,
  parameter int SCORE_MAX     = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        update,
  input  logic [7:0]  xObstacle,
  input  logic [8:0]  yObstacle,
  input  logic [7:0]  xPlayer,
  input  logic [8:0]  yPlayer,
  output logic        collision,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic        invulnerable,
  output logic        gameOver,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LATCH, COMPARE, RESOLVE, GAME_OVER} state_t;
  state_t      state;
  logic [7:0]  xo_q, xp_q, cooldown;
  logic [8:0]  yo_q, yp_q, y_prev;
  logic        hit, hit_this_pass, prev_valid;
  logic [9:0]  x_o, x_p, y_o, y_p;
  logic        overlap, respawn, accept;
  logic [1:0]  lives_nxt;
  logic [13:0] score_nxt;
  // widen to 10 bits so the right/bottom edges never wrap near the screen limit
  assign x_o = {2'b0, xo_q};
  assign x_p = {2'b0, xp_q};
  assign y_o = {1'b0, yo_q};
  assign y_p = {1'b0, yp_q};
  assign overlap = (x_o < x_p + 10'(PLAYER_W)) && (x_p < x_o + 10'(OBSTACLE_W)) &&
                   (y_o < y_p + 10'(PLAYER_H)) && (y_p < y_o + 10'(OBSTACLE_H));
  assign respawn = prev_valid && (yo_q > y_prev);
  assign accept = hit && (cooldown == 8'd0) && (lives != 2'd0);
  assign lives_nxt = accept ? lives - 2'd1 : lives;
  assign score_nxt = (respawn && !hit_this_pass && score < 14'(SCORE_MAX)) ? score + 14'd1 : score;
  assign invulnerable = (cooldown != 8'd0);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      collision <= 1'b0;
      lives <= 2'(LIVES_INIT);
      score <= '0;
      gameOver <= 1'b0;
      busy <= 1'b0;
      cooldown <= '0;
      hit_this_pass <= 1'b0;
      prev_valid <= 1'b0;
      hit <= 1'b0;
      xo_q <= '0;
      xp_q <= '0;
      yo_q <= '0;
      yp_q <= '0;
      y_prev <= '0;
    end else begin
      collision <= 1'b0;
      case (state)
        IDLE: if (update) begin
          state <= LATCH;
          busy <= 1'b1;
          xo_q <= xObstacle;
          yo_q <= yObstacle;
          xp_q <= xPlayer;
          yp_q <= yPlayer;
          cooldown <= invulnerable ? cooldown - 8'd1 : cooldown;
        end
        LATCH: begin
          hit <= overlap;
          state <= COMPARE;
        end
        COMPARE: state <= RESOLVE;
        RESOLVE: begin
          busy <= 1'b0;
          score <= score_nxt;
          lives <= lives_nxt;
          collision <= accept;
          cooldown <= accept ? 8'(INVULN_FRAMES) : cooldown;
          // a respawn closes the old pass first, then an accepted hit marks the new one
          hit_this_pass <= accept | (hit_this_pass & ~respawn);
          y_prev <= yo_q;
          prev_valid <= 1'b1;
          gameOver <= (lives_nxt == 2'd0);
          state <= (lives_nxt == 2'd0) ? GAME_OVER : IDLE;
        end
        default: state <= GAME_OVER;
      endcase
    end
  end
endmodule

// File: tb/tb_obstacle_collision.sv
// tb_obstacle_collision: directed table, corner sequences and randomized frames against a frame-level model
module tb_obstacle_collision;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        update = 1'b0;
  logic [7:0]  xObstacle = '0, xPlayer = '0;
  logic [8:0]  yObstacle = '0, yPlayer = '0;
  logic        collision, invulnerable, gameOver, busy;
  logic [1:0]  lives;
  logic [13:0] score;
  logic        s_collision, s_invulnerable, s_gameOver, s_busy;
  logic [1:0]  s_lives;
  logic [13:0] s_score;
  int vectors = 0;
  int errors = 0;
  int m_lives, m_passes, m_cd, m_yprev;
  bit m_flag, m_pv, m_go;
  typedef struct {int xo; int yo; int xp; int yp; int coll; int lives; int score; int inv;} vec_t;
  vec_t tbl[12];
  always #5 clock = ~clock;
  obstacle_collision dut (
    .clock(clock), .reset(reset), .update(update),
    .xObstacle(xObstacle), .yObstacle(yObstacle), .xPlayer(xPlayer), .yPlayer(yPlayer),
    .collision(collision), .lives(lives), .score(score),
    .invulnerable(invulnerable), .gameOver(gameOver), .busy(busy)
  );
  obstacle_collision #(.SCORE_MAX(3)) dut_sat (
    .clock(clock), .reset(reset), .update(update),
    .xObstacle(xObstacle), .yObstacle(yObstacle), .xPlayer(xPlayer), .yPlayer(yPlayer),
    .collision(s_collision), .lives(s_lives), .score(s_score),
    .invulnerable(s_invulnerable), .gameOver(s_gameOver), .busy(s_busy)
  );
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic void model_reset();
    m_lives = 3; m_passes = 0; m_cd = 0; m_yprev = 0;
    m_flag = 0; m_pv = 0; m_go = 0;
  endfunction
  function automatic bit model_frame(input int xo, input int yo, input int xp, input int yp);
    bit hit, acc;
    if (m_go) return 1'b0;
    if (m_cd > 0) m_cd--;
    hit = (xo < xp + 16) && (xp < xo + 16) && (yo < yp + 16) && (yp < yo + 16);
    if (m_pv && yo > m_yprev) begin
      if (!m_flag) m_passes++;
      m_flag = 0;
    end
    acc = hit && m_cd == 0;
    if (acc) begin
      m_lives--; m_cd = 30; m_flag = 1;
    end
    m_yprev = yo; m_pv = 1;
    if (m_lives == 0) m_go = 1;
    return acc;
  endfunction
  function automatic int smin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  task automatic check_idle_state(input string tag);
    check({tag, "_lives"}, lives, m_lives);
    check({tag, "_score"}, score, smin(m_passes, 9999));
    check({tag, "_score_sat"}, s_score, smin(m_passes, 3));
    check({tag, "_invulnerable"}, invulnerable, m_cd != 0);
    check({tag, "_gameover"}, gameOver, m_go);
    check({tag, "_busy_idle"}, busy, 0);
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    update = 1'b0;
    @(negedge clock);
    model_reset();
    check("rst_collision", collision, 0);
    check_idle_state("rst");
    reset = 1'b1;
  endtask
  task automatic run_frame(input int xo, input int yo, input int xp, input int yp, input bit poke, output int coll);
    int bc, cc, cpos;
    bit was_go, acc;
    @(negedge clock);
    xObstacle = 8'(xo); yObstacle = 9'(yo); xPlayer = 8'(xp); yPlayer = 9'(yp);
    update = 1'b1;
    bc = 0; cc = 0; cpos = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      update = poke && k == 1;
      if (update) begin
        xObstacle = 8'(xp); yObstacle = 9'(yp);
      end
      if (busy) bc++;
      if (collision) begin
        cc++; cpos = k;
      end
    end
    update = 1'b0;
    was_go = m_go;
    acc = model_frame(xo, yo, xp, yp);
    check("busy_cycles", bc, was_go ? 0 : 3);
    check("collision_pulses", cc, int'(acc));
    check("collision_latency", cpos, acc ? 4 : -1);
    check_idle_state("frame");
    coll = cc;
  endtask
  initial begin
    int c;
    tbl[0]  = '{95, 419, 10, 40, 0, 3, 0, 0};
    tbl[1]  = '{95, 419, 10, 40, 0, 3, 0, 0};
    tbl[2]  = '{95, 419, 10, 40, 0, 3, 0, 0};
    tbl[3]  = '{95, 419, 10, 40, 0, 3, 0, 0};
    tbl[4]  = '{95, 419, 10, 40, 0, 3, 0, 0};
    tbl[5]  = '{26,  45, 10, 40, 0, 3, 0, 0};
    tbl[6]  = '{25,  45, 10, 40, 1, 2, 0, 1};
    tbl[7]  = '{95, 419, 10, 40, 0, 2, 0, 1};
    tbl[8]  = '{95, 300, 10, 40, 0, 2, 0, 1};
    tbl[9]  = '{95, 100, 10, 40, 0, 2, 0, 1};
    tbl[10] = '{95,  40, 10, 40, 0, 2, 0, 1};
    tbl[11] = '{95, 419, 10, 40, 0, 2, 1, 1};
    model_reset();
    repeat (2) @(negedge clock);
    do_reset();
    foreach (tbl[i]) begin
      run_frame(tbl[i].xo, tbl[i].yo, tbl[i].xp, tbl[i].yp, 1'b0, c);
      check("tbl_collision", c, tbl[i].coll);
      check("tbl_lives", lives, tbl[i].lives);
      check("tbl_score", score, tbl[i].score);
      check("tbl_invulnerable", invulnerable, tbl[i].inv);
    end
    // clean pass sequence that contains a hit at yO=40 scores nothing
    do_reset();
    foreach (tbl[i]) if (i >= 7) run_frame(i == 10 ? 20 : 95, tbl[i].yo, 10, 40, 1'b0, c);
    check("hit_pass_score", score, 0);
    // hit coinciding with a respawn
    do_reset();
    run_frame(95, 100, 10, 200, 1'b0, c);
    run_frame(95, 40, 10, 200, 1'b0, c);
    run_frame(20, 210, 10, 200, 1'b0, c);
    check("respawn_hit_pulse", c, 1);
    check("respawn_hit_score", score, 1);
    run_frame(95, 300, 10, 200, 1'b0, c);
    check("new_pass_unscored", score, 1);
    // update while busy is ignored
    do_reset();
    run_frame(95, 419, 10, 40, 1'b1, c);
    check("busy_poke_no_hit", c, 0);
    // cooldown and three spaced hits to game over
    do_reset();
    for (int n = 1; n <= 64; n++) begin
      run_frame(20, 45, 10, 40, 1'b0, c);
      if (n == 31) check("second_hit_lives", lives, 1);
      if (n == 30) check("cooldown_last_blocked", c, 0);
    end
    check("gameover_lives", lives, 0);
    check("gameover_flag", gameOver, 1);
    do_reset();
    check("restore_lives", lives, 3);
    // reset pulled during COMPARE of a hit
    run_frame(95, 100, 10, 40, 1'b0, c);
    run_frame(95, 419, 10, 40, 1'b0, c);
    @(negedge clock);
    xObstacle = 8'd20; yObstacle = 9'd45; update = 1'b1;
    @(negedge clock);
    update = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    c = 0;
    repeat (3) begin
      @(negedge clock);
      c += int'(collision);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      c += int'(collision);
    end
    model_reset();
    check("abort_no_pulse", c, 0);
    check_idle_state("abort");
    // randomized frames, including busy pokes and idle gaps
    do_reset();
    for (int n = 0; n < 220; n++) begin
      int xo, yo, xp, yp;
      xp = $urandom_range(10, 40);
      yp = $urandom_range(40, 60);
      xo = $urandom_range(0, 70);
      yo = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 75) : $urandom_range(0, 511);
      run_frame(xo, yo, xp, yp, $urandom_range(0, 3) == 0, c);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if (m_go && $urandom_range(0, 2) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
